// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

   localparam int FETCH_DATA_W   = 32;
   localparam int FETCH_MEM_LEN  = 32;
   localparam int FETCH_RESET_PC = 0;

   // Address width for a given ROM depth; a one-word ROM still needs one address bit.
   function automatic int fetch_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int FETCH_ADDR_W = fetch_addr_w(FETCH_MEM_LEN);

   typedef struct packed {
      logic [FETCH_DATA_W-1:0] instr;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {instr, pc} that decode could not take.
module fetch_skid_buf
   import fetch_pkg::*;
#(
   parameter type pkt_t = fetch_pkt_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_clear,
   input  logic i_pop,
   input  pkt_t i_pkt,
   output logic o_valid,
   output pkt_t o_pkt
);

   logic r_valid;
   pkt_t r_pkt;

   // Clear (redirect) dominates load; pop only empties an occupied entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
      end else if (i_pop) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_load && !i_clear) begin
         r_pkt <= i_pkt;
      end
   end

   assign o_valid = r_valid;
   assign o_pkt   = r_pkt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, hides the ROM's 1-cycle read latency and
// hands {instr, pc} to decode over valid/ready with a skid buffer and redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DATA_LENGTH = FETCH_DATA_W,
   parameter int MEM_LENGTH  = FETCH_MEM_LEN,
   parameter int RESET_PC    = FETCH_RESET_PC,
   localparam int ADDR_W     = fetch_addr_w(MEM_LENGTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fetch_en,
   output logic [ADDR_W-1:0]      rom_address,
   input  logic [DATA_LENGTH-1:0] rom_data,
   input  logic                   branch_valid,
   input  logic [ADDR_W-1:0]      branch_target,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [DATA_LENGTH-1:0] instr_data,
   output logic [ADDR_W-1:0]      instr_pc
);

   typedef struct packed {
      logic [DATA_LENGTH-1:0] instr;
      logic [ADDR_W-1:0]      pc;
   } pkt_t;

   logic [ADDR_W-1:0] r_req_pc;
   logic              r_resp_valid;
   logic [ADDR_W-1:0] r_resp_pc;

   logic              w_skid_valid;
   pkt_t              w_skid_pkt;
   pkt_t              w_resp_pkt;
   logic              w_pop;
   logic [1:0]        w_pending;
   logic              w_issue;
   logic              w_skid_load;
   logic [ADDR_W-1:0] w_next_pc;

   assign w_pop     = instr_valid & instr_ready;
   assign w_pending = {1'b0, w_skid_valid} + {1'b0, r_resp_valid};
   // Only issue when everything outstanding leaves this cycle, so the skid can never overflow.
   assign w_issue   = fetch_en & ~branch_valid & ((w_pending - {1'b0, w_pop}) == 2'd0);

   // Explicit wrap so non-power-of-2 depths stay in range.
   assign w_next_pc = (r_req_pc == ADDR_W'(MEM_LENGTH - 1)) ? '0 : r_req_pc + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_pc     <= ADDR_W'(RESET_PC);
         r_resp_valid <= 1'b0;
      end else begin
         r_resp_valid <= w_issue;
         if (branch_valid) begin
            r_req_pc <= branch_target;
         end else if (w_issue) begin
            r_req_pc <= w_next_pc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_resp_pc <= r_req_pc;
      end
   end

   assign w_resp_pkt  = '{instr: rom_data, pc: r_resp_pc};
   assign w_skid_load = r_resp_valid & ~w_skid_valid & ~w_pop & ~branch_valid;

   fetch_skid_buf #(
      .pkt_t (pkt_t)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_skid_load),
      .i_clear (branch_valid),
      .i_pop   (w_pop & w_skid_valid),
      .i_pkt   (w_resp_pkt),
      .o_valid (w_skid_valid),
      .o_pkt   (w_skid_pkt)
   );

   assign rom_address = r_req_pc;
   assign instr_valid = ~branch_valid & (w_skid_valid | r_resp_valid);
   assign instr_data  = w_skid_valid ? w_skid_pkt.instr : rom_data;
   assign instr_pc    = w_skid_valid ? w_skid_pkt.pc    : r_resp_pc;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(w_skid_valid && r_resp_valid && !w_pop))
            else $error("fetch_unit: skid and response both held without a pop");
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a preloaded synchronous ROM (word i = 0xA000_0000+i).
module tb_fetch_unit;

   localparam int DW = 32;
   localparam int ML = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_en;
   logic [AW-1:0] rom_address;
   logic [DW-1:0] rom_data;
   logic          branch_valid;
   logic [AW-1:0] branch_target;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr_data;
   logic [AW-1:0] instr_pc;

   logic [DW-1:0] rom [ML];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < ML; i++) rom[i] = 32'hA000_0000 + i;
   end

   always @(posedge clk) rom_data <= rom[rom_address];

   fetch_unit #(
      .DATA_LENGTH (DW),
      .MEM_LENGTH  (ML),
      .RESET_PC    (0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_en      (fetch_en),
      .rom_address   (rom_address),
      .rom_data      (rom_data),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_data    (instr_data),
      .instr_pc      (instr_pc)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_instr(input string tag, input int pc);
      check_eq($sformatf("%s_valid", tag), 64'(instr_valid), 64'd1);
      check_eq($sformatf("%s_pc", tag),    64'(instr_pc),    64'(pc));
      check_eq($sformatf("%s_data", tag),  64'(instr_data),  64'(32'hA000_0000 + pc));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      fetch_en      = 1'b0;
      branch_valid  = 1'b0;
      branch_target = '0;
      instr_ready   = 1'b0;
      #1;
      check_eq("rst_valid", 64'(instr_valid), 64'd0);
      check_eq("rst_addr",  64'(rom_address), 64'd0);
      tick();
      tick();

      // Release reset between edges; this cycle issues pc 0.
      rst_n       = 1'b1;
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      #1;
      check_eq("first_valid", 64'(instr_valid), 64'd0);
      check_eq("first_addr",  64'(rom_address), 64'd0);
      tick();

      // Stream through the wrap 31 -> 0 with no bubble.
      for (int i = 0; i < 34; i++) begin
         #1;
         expect_instr($sformatf("stream%0d", i), i % 32);
         tick();
      end
      for (int p = 2; p < 5; p++) begin
         #1;
         expect_instr($sformatf("pre_stall%0d", p), p);
         tick();
      end

      // Stall three cycles with pc 5 presented.
      instr_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         expect_instr($sformatf("stall%0d", s), 5);
         tick();
      end
      instr_ready = 1'b1;
      #1;
      expect_instr("resume5", 5);
      tick();
      #1;
      expect_instr("resume6", 6);
      tick();
      #1;
      expect_instr("resume7", 7);
      tick();

      // Branch to 20 while streaming (pc 8 would have been presented).
      branch_valid  = 1'b1;
      branch_target = 5'd20;
      #1;
      check_eq("br_T_valid", 64'(instr_valid), 64'd0);
      tick();
      branch_valid = 1'b0;
      #1;
      check_eq("br_T1_valid", 64'(instr_valid), 64'd0);
      check_eq("br_T1_addr",  64'(rom_address), 64'd20);
      tick();
      #1;
      expect_instr("br_T2", 20);
      tick();
      #1;
      expect_instr("br_T3", 21);
      tick();

      // Fill the skid with pc 22, then branch to 3 during the stall.
      instr_ready = 1'b0;
      #1;
      expect_instr("skid_fill", 22);
      tick();
      #1;
      expect_instr("skid_held", 22);
      branch_valid  = 1'b1;
      branch_target = 5'd3;
      #1;
      check_eq("skbr_T_valid", 64'(instr_valid), 64'd0);
      tick();
      branch_valid = 1'b0;
      instr_ready  = 1'b1;
      #1;
      check_eq("skbr_T1_valid", 64'(instr_valid), 64'd0);
      tick();
      #1;
      expect_instr("skbr_T2", 3);
      tick();
      #1;
      expect_instr("skbr_T3", 4);
      tick();

      // fetch_en low: pc 5 drains, then nothing issues and req_pc freezes at 6.
      fetch_en = 1'b0;
      #1;
      expect_instr("fen_drain", 5);
      tick();
      #1;
      check_eq("fen_off1_valid", 64'(instr_valid), 64'd0);
      check_eq("fen_off1_addr",  64'(rom_address), 64'd6);
      tick();
      #1;
      check_eq("fen_off2_valid", 64'(instr_valid), 64'd0);
      check_eq("fen_off2_addr",  64'(rom_address), 64'd6);
      fetch_en = 1'b1;
      tick();
      #1;
      expect_instr("fen_resume", 6);
      tick();
      #1;
      expect_instr("pre_rst", 7);

      // Asynchronous reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 64'(instr_valid), 64'd0);
      check_eq("arst_addr",  64'(rom_address), 64'd0);
      tick();
      check_eq("arst_hold_valid", 64'(instr_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      check_eq("arst_rel_valid", 64'(instr_valid), 64'd0);
      tick();
      #1;
      expect_instr("arst_pc0", 0);
      tick();
      #1;
      expect_instr("arst_pc1", 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
